// File: rtl/latch_ex_mem.sv
// Execute-to-memory pipeline register.
// Carries the GPR and hi/lo write-back results, the partial product and step
// count of two-cycle multiply-accumulate operations back to execute, and a
// saturating count of the bubbles inserted since reset.
module latch_ex_mem #(
    parameter int DATA_WIDTH           = 32,
    parameter int ADDRESS_WIDTH        = 5,
    parameter int COUNT_WIDTH          = 2,
    parameter int BUBBLE_COUNTER_WIDTH = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            stall_ex,
    input  logic                            stall_mem,
    input  logic                            flush,
    input  logic                            ex_register_write_enable,
    input  logic [ADDRESS_WIDTH-1:0]        ex_register_write_address,
    input  logic [DATA_WIDTH-1:0]           ex_register_write_data,
    input  logic                            ex_register_hi_write_enable,
    input  logic [DATA_WIDTH-1:0]           ex_register_hi_write_data,
    input  logic                            ex_register_lo_write_enable,
    input  logic [DATA_WIDTH-1:0]           ex_register_lo_write_data,
    input  logic [2*DATA_WIDTH-1:0]         ex_accumulate_data,
    input  logic [COUNT_WIDTH-1:0]          ex_accumulate_count,
    output logic                            mem_register_write_enable,
    output logic [ADDRESS_WIDTH-1:0]        mem_register_write_address,
    output logic [DATA_WIDTH-1:0]           mem_register_write_data,
    output logic                            mem_register_hi_write_enable,
    output logic [DATA_WIDTH-1:0]           mem_register_hi_write_data,
    output logic                            mem_register_lo_write_enable,
    output logic [DATA_WIDTH-1:0]           mem_register_lo_write_data,
    output logic [2*DATA_WIDTH-1:0]         accumulate_data,
    output logic [COUNT_WIDTH-1:0]          accumulate_count,
    output logic [BUBBLE_COUNTER_WIDTH-1:0] bubble_count
);

    // What the register does on the next rising edge.
    typedef enum logic [1:0] {
        ACT_CAPTURE,
        ACT_BUBBLE,
        ACT_HOLD,
        ACT_FLUSH
    } action_t;

    action_t action;

    // Data paths with disabled enables forced to zero before registering.
    logic [DATA_WIDTH-1:0] gated_write_data;
    logic [DATA_WIDTH-1:0] gated_hi_data;
    logic [DATA_WIDTH-1:0] gated_lo_data;

    // Next bubble count, holding at all-ones once saturated.
    logic [BUBBLE_COUNTER_WIDTH-1:0] bubble_count_next;

    // Decode the stall/flush controls in priority order; a downstream-only
    // stall cannot legally happen and is folded into hold.
    always_comb begin
        action = ACT_CAPTURE;
        if (flush)
            action = ACT_FLUSH;
        else if (stall_ex && !stall_mem)
            action = ACT_BUBBLE;
        else if (stall_ex || stall_mem)
            action = ACT_HOLD;
    end

    // Zero the data of any write whose enable is off.
    always_comb begin
        gated_write_data = '0;
        gated_hi_data    = '0;
        gated_lo_data    = '0;
        if (ex_register_write_enable)
            gated_write_data = ex_register_write_data;
        if (ex_register_hi_write_enable)
            gated_hi_data = ex_register_hi_write_data;
        if (ex_register_lo_write_enable)
            gated_lo_data = ex_register_lo_write_data;
    end

    // Saturating increment of the bubble counter.
    always_comb begin
        bubble_count_next = bubble_count;
        if (bubble_count != '1)
            bubble_count_next = bubble_count + 1'b1;
    end

    // Pipeline register state update.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_register_write_enable    <= 1'b0;
            mem_register_write_address   <= '0;
            mem_register_write_data      <= '0;
            mem_register_hi_write_enable <= 1'b0;
            mem_register_hi_write_data   <= '0;
            mem_register_lo_write_enable <= 1'b0;
            mem_register_lo_write_data   <= '0;
            accumulate_data              <= '0;
            accumulate_count             <= '0;
            bubble_count                 <= '0;
        end else begin
            case (action)
                ACT_FLUSH: begin
                    mem_register_write_enable    <= 1'b0;
                    mem_register_write_address   <= '0;
                    mem_register_write_data      <= '0;
                    mem_register_hi_write_enable <= 1'b0;
                    mem_register_hi_write_data   <= '0;
                    mem_register_lo_write_enable <= 1'b0;
                    mem_register_lo_write_data   <= '0;
                    accumulate_data              <= '0;
                    accumulate_count             <= '0;
                end
                ACT_BUBBLE: begin
                    mem_register_write_enable    <= 1'b0;
                    mem_register_write_address   <= '0;
                    mem_register_write_data      <= '0;
                    mem_register_hi_write_enable <= 1'b0;
                    mem_register_hi_write_data   <= '0;
                    mem_register_lo_write_enable <= 1'b0;
                    mem_register_lo_write_data   <= '0;
                    accumulate_data              <= ex_accumulate_data;
                    accumulate_count             <= ex_accumulate_count;
                    bubble_count                 <= bubble_count_next;
                end
                ACT_HOLD: begin
                    // every register keeps its value
                end
                default: begin
                    mem_register_write_enable    <= ex_register_write_enable;
                    mem_register_write_address   <= ex_register_write_address;
                    mem_register_write_data      <= gated_write_data;
                    mem_register_hi_write_enable <= ex_register_hi_write_enable;
                    mem_register_hi_write_data   <= gated_hi_data;
                    mem_register_lo_write_enable <= ex_register_lo_write_enable;
                    mem_register_lo_write_data   <= gated_lo_data;
                    accumulate_data              <= '0;
                    accumulate_count             <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latch_ex_mem.sv
// Directed bench for latch_ex_mem with a 4-bit bubble counter so that
// saturation is reachable in a short run.
module tb_latch_ex_mem;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 2;
    localparam int BW = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic            stall_ex, stall_mem, flush;
    logic            ex_we;
    logic [AW-1:0]   ex_wa;
    logic [DW-1:0]   ex_wd;
    logic            ex_hi_we;
    logic [DW-1:0]   ex_hi_wd;
    logic            ex_lo_we;
    logic [DW-1:0]   ex_lo_wd;
    logic [2*DW-1:0] ex_acc;
    logic [CW-1:0]   ex_cnt;
    logic            mem_we;
    logic [AW-1:0]   mem_wa;
    logic [DW-1:0]   mem_wd;
    logic            mem_hi_we;
    logic [DW-1:0]   mem_hi_wd;
    logic            mem_lo_we;
    logic [DW-1:0]   mem_lo_wd;
    logic [2*DW-1:0] acc;
    logic [CW-1:0]   cnt;
    logic [BW-1:0]   bubbles;

    int n_checks = 0;
    int n_fail   = 0;

    latch_ex_mem #(
        .DATA_WIDTH(DW),
        .ADDRESS_WIDTH(AW),
        .COUNT_WIDTH(CW),
        .BUBBLE_COUNTER_WIDTH(BW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .stall_ex(stall_ex),
        .stall_mem(stall_mem),
        .flush(flush),
        .ex_register_write_enable(ex_we),
        .ex_register_write_address(ex_wa),
        .ex_register_write_data(ex_wd),
        .ex_register_hi_write_enable(ex_hi_we),
        .ex_register_hi_write_data(ex_hi_wd),
        .ex_register_lo_write_enable(ex_lo_we),
        .ex_register_lo_write_data(ex_lo_wd),
        .ex_accumulate_data(ex_acc),
        .ex_accumulate_count(ex_cnt),
        .mem_register_write_enable(mem_we),
        .mem_register_write_address(mem_wa),
        .mem_register_write_data(mem_wd),
        .mem_register_hi_write_enable(mem_hi_we),
        .mem_register_hi_write_data(mem_hi_wd),
        .mem_register_lo_write_enable(mem_lo_we),
        .mem_register_lo_write_data(mem_lo_wd),
        .accumulate_data(acc),
        .accumulate_count(cnt),
        .bubble_count(bubbles)
    );

    always #5 clock = ~clock;

    // A downstream-only stall is never legal stimulus.
    always @(posedge clock) begin
        if (!reset)
            assert (!(stall_mem && !stall_ex))
            else begin
                n_fail++;
                $error("FAIL illegal_stall: stall_ex=0 stall_mem=1 observed");
            end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_mem_clear(input string tag);
        check({tag, "_we"},    {63'd0, mem_we},    64'd0);
        check({tag, "_wd"},    {32'd0, mem_wd},    64'd0);
        check({tag, "_hi_we"}, {63'd0, mem_hi_we}, 64'd0);
        check({tag, "_hi_wd"}, {32'd0, mem_hi_wd}, 64'd0);
        check({tag, "_lo_we"}, {63'd0, mem_lo_we}, 64'd0);
        check({tag, "_lo_wd"}, {32'd0, mem_lo_wd}, 64'd0);
    endtask

    initial begin
        reset = 1'b1; stall_ex = 1'b0; stall_mem = 1'b0; flush = 1'b0;
        ex_we = 1'b0; ex_wa = '0; ex_wd = '0;
        ex_hi_we = 1'b0; ex_hi_wd = '0; ex_lo_we = 1'b0; ex_lo_wd = '0;
        ex_acc = '0; ex_cnt = '0;
        step(); step();
        reset = 1'b0;
        #1;
        check_mem_clear("reset");
        check("reset_acc", acc, 64'd0);
        check("reset_bubbles", {60'd0, bubbles}, 64'd0);

        // Capture with write enable set, lo disabled but carrying data.
        ex_we = 1'b1; ex_wa = 5'd9; ex_wd = 32'hDEADBEEF;
        ex_hi_we = 1'b1; ex_hi_wd = 32'hAAAA0001;
        ex_lo_we = 1'b0; ex_lo_wd = 32'h00000055;
        step();
        check("cap_we", {63'd0, mem_we}, 64'd1);
        check("cap_wa", {59'd0, mem_wa}, 64'd9);
        check("cap_wd", {32'd0, mem_wd}, 64'hDEADBEEF);
        check("cap_hi_we", {63'd0, mem_hi_we}, 64'd1);
        check("cap_hi_wd", {32'd0, mem_hi_wd}, 64'hAAAA0001);
        check("cap_lo_we", {63'd0, mem_lo_we}, 64'd0);
        check("cap_lo_wd_gated", {32'd0, mem_lo_wd}, 64'd0);

        // Disabled GPR write carries zero data.
        ex_we = 1'b0; ex_wd = 32'h1234;
        ex_hi_we = 1'b0; ex_lo_we = 1'b1; ex_lo_wd = 32'h0BADF00D;
        step();
        check("dis_we", {63'd0, mem_we}, 64'd0);
        check("dis_wd_gated", {32'd0, mem_wd}, 64'd0);
        check("dis_hi_wd_gated", {32'd0, mem_hi_wd}, 64'd0);
        check("dis_lo_wd", {32'd0, mem_lo_wd}, 64'h0BADF00D);

        // Bubble: partial product is fed back, counter increments.
        ex_we = 1'b1; ex_wd = 32'h11111111;
        stall_ex = 1'b1;
        ex_acc = 64'h0000_0001_FFFF_FFFE; ex_cnt = 2'd1;
        step();
        check_mem_clear("bub");
        check("bub_acc", acc, 64'h0000_0001_FFFF_FFFE);
        check("bub_cnt", {62'd0, cnt}, 64'd1);
        check("bub_bubbles", {60'd0, bubbles}, 64'd1);

        // Hold for three cycles with changing inputs.
        stall_mem = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ex_acc = 64'h1234_5678_0000_0000 + 64'(i);
            ex_cnt = 2'(i + 2);
            ex_we = 1'b1; ex_wa = 5'(i + 20); ex_wd = 32'hF0F0_0000 + 32'(i);
            ex_hi_we = 1'b1; ex_lo_we = 1'b1;
            step();
            check("hold_we", {63'd0, mem_we}, 64'd0);
            check("hold_wd", {32'd0, mem_wd}, 64'd0);
            check("hold_acc", acc, 64'h0000_0001_FFFF_FFFE);
            check("hold_cnt", {62'd0, cnt}, 64'd1);
            check("hold_bubbles", {60'd0, bubbles}, 64'd1);
        end

        // Release both stalls: capture and clear the accumulator.
        stall_ex = 1'b0; stall_mem = 1'b0;
        ex_we = 1'b1; ex_wa = 5'd3; ex_wd = 32'hCAFE0000;
        ex_hi_we = 1'b1; ex_hi_wd = 32'h00C0FFEE;
        ex_lo_we = 1'b1; ex_lo_wd = 32'h7777AAAA;
        step();
        check("rel_we", {63'd0, mem_we}, 64'd1);
        check("rel_wa", {59'd0, mem_wa}, 64'd3);
        check("rel_wd", {32'd0, mem_wd}, 64'hCAFE0000);
        check("rel_hi_wd", {32'd0, mem_hi_wd}, 64'h00C0FFEE);
        check("rel_lo_wd", {32'd0, mem_lo_wd}, 64'h7777AAAA);
        check("rel_acc", acc, 64'd0);
        check("rel_cnt", {62'd0, cnt}, 64'd0);
        check("rel_bubbles", {60'd0, bubbles}, 64'd1);

        // Bubble to load a partial product, then flush over a bubble request.
        stall_ex = 1'b1; ex_acc = 64'hABCD_0000_0000_0042; ex_cnt = 2'd2;
        step();
        check("bub2_acc", acc, 64'hABCD_0000_0000_0042);
        check("bub2_bubbles", {60'd0, bubbles}, 64'd2);
        stall_ex = 1'b0;
        step();
        check("cap2_we", {63'd0, mem_we}, 64'd1);
        flush = 1'b1; stall_ex = 1'b1; ex_acc = 64'h5555; ex_cnt = 2'd3;
        step();
        check_mem_clear("flush");
        check("flush_acc", acc, 64'd0);
        check("flush_cnt", {62'd0, cnt}, 64'd0);
        check("flush_bubbles", {60'd0, bubbles}, 64'd2);
        flush = 1'b0;

        // Saturation: 2 + 12 bubbles = 14, then 8 more pin at 15.
        for (int i = 0; i < 12; i++) step();
        check("sat_14", {60'd0, bubbles}, 64'hE);
        step();
        check("sat_15", {60'd0, bubbles}, 64'hF);
        for (int i = 0; i < 7; i++) step();
        check("sat_hold", {60'd0, bubbles}, 64'hF);

        // Asynchronous reset in mid-cycle with nonzero outputs.
        stall_ex = 1'b1; ex_acc = 64'h9999_8888_7777_6666; ex_cnt = 2'd1;
        step();
        stall_ex = 1'b0; ex_we = 1'b1; ex_wa = 5'd17; ex_wd = 32'h13572468;
        step();
        check("pre_rst_we", {63'd0, mem_we}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check_mem_clear("arst");
        check("arst_wa", {59'd0, mem_wa}, 64'd0);
        check("arst_acc", acc, 64'd0);
        check("arst_cnt", {62'd0, cnt}, 64'd0);
        check("arst_bubbles", {60'd0, bubbles}, 64'd0);
        step();
        reset = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/latch_ex_mem.md
Name: latch_ex_mem

Overview:
Pipeline register between the execute stage and the memory stage. It captures the execute-stage results each cycle:
- GPR write enable, address and data
- hi/lo write enables and data

It honours the pipeline stall and flush controls. It also holds the intermediate 64-bit product and cycle counter for two-cycle multiply-accumulate operators, and feeds them back to execute. It keeps a saturating bubble counter for performance debug.

Parameters:
DATA_WIDTH, 32, width of GPR/hi/lo data
ADDRESS_WIDTH, 5, GPR write address width
COUNT_WIDTH, 2, width of the multi-cycle operation counter
BUBBLE_COUNTER_WIDTH, 16, width of the saturating bubble counter

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset (`RESET_ENABLE); one clock, reset asynchronous active-high
stall_ex  input  1  execute stage (or anything upstream) is stalled this cycle
stall_mem  input  1  memory stage (or anything downstream) is stalled this cycle
flush  input  1  exception/branch flush; kills the contents
ex_register_write_enable  input  1  GPR write enable from execute
ex_register_write_address  input  ADDRESS_WIDTH  GPR destination
ex_register_write_data  input  DATA_WIDTH  GPR result
ex_register_hi_write_enable  input  1  hi write enable
ex_register_hi_write_data  input  DATA_WIDTH  hi data
ex_register_lo_write_enable  input  1  lo write enable
ex_register_lo_write_data  input  DATA_WIDTH  lo data
ex_accumulate_data  input  2*DATA_WIDTH  partial product from execute
ex_accumulate_count  input  COUNT_WIDTH  execute's current multi-cycle step
mem_register_write_enable  output  1  registered GPR write enable
mem_register_write_address  output  ADDRESS_WIDTH  registered destination
mem_register_write_data  output  DATA_WIDTH  registered GPR data
mem_register_hi_write_enable  output  1  registered hi enable
mem_register_hi_write_data  output  DATA_WIDTH  registered hi data
mem_register_lo_write_enable  output  1  registered lo enable
mem_register_lo_write_data  output  DATA_WIDTH  registered lo data
accumulate_data  output  2*DATA_WIDTH  held partial product fed back to execute
accumulate_count  output  COUNT_WIDTH  held step count fed back to execute
bubble_count  output  BUBBLE_COUNTER_WIDTH  number of bubbles inserted since reset, saturating

Behaviour:
- Reset (asynchronous, any time, including mid multi-cycle operation): every output goes to 0, with enables at `WRITE_DISABLE.
- Priority on each rising edge: flush > (stall_ex && !stall_mem) > (stall_ex && stall_mem) > capture.
- flush=1:
  - All mem_* outputs and enables are cleared.
  - accumulate_data and accumulate_count are cleared.
  - bubble_count is unchanged.
- Bubble (stall_ex=1, stall_mem=0):
  - All mem_* enables and data are cleared.
  - accumulate_data/count latch ex_accumulate_data/count, so execute sees its partial result next cycle.
  - bubble_count increments and saturates at all-ones.
- Hold (stall_ex=1, stall_mem=1): every register keeps its value, including accumulate and counter.
- Stall_ex=0, stall_mem=1: illegal combination (a downstream stall always implies an upstream stall). Treat it as hold; the bench asserts that it never occurs.
- Capture (stall_ex=0, stall_mem=0):
  - All ex_* values are registered to the mem_* outputs.
  - accumulate_data and accumulate_count are cleared to 0, so each multi-cycle op starts fresh.
- Latency: exactly one cycle from ex_* input to mem_* output when not stalled.
- Disabled enables always come with zero data. When an ex_* enable is 0, the corresponding mem_* data output is registered as 0 rather than passed through.
- No combinational path from any input to any output.

Test Plan:
- Reset: assert reset asynchronously mid-cycle while outputs are nonzero -> all outputs read 0 immediately, with no clock edge needed.
- Capture: write enable=1, address=5'd9, data=32'hDEADBEEF, no stall -> next cycle mem_register_write_* = 1 / 9 / DEADBEEF; with enable=0 and data=32'h1234 -> mem data=0.
- Bubble: stall_ex=1, stall_mem=0, ex_accumulate_data=64'h0000_0001_FFFF_FFFE, count=2'd1 -> after the edge all mem_* enables are 0, accumulate_data=0000_0001_FFFF_FFFE, accumulate_count=1, bubble_count=1.
- Hold: after the bubble above, raise stall_mem for 3 cycles with changing inputs -> all outputs stay constant; bubble_count stays 1; releasing both stalls captures the new inputs and clears accumulate to 0.
- Flush priority: flush=1 together with stall_ex=1, stall_mem=0 -> all outputs clear; bubble_count does not increment.
- Saturation: with BUBBLE_COUNTER_WIDTH=4, insert 20 bubbles -> bubble_count=4'hF and stays there.
